// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes and RMW FSM states.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_e;

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane handling: load extract/extend (MERGE=0) or store merge (MERGE=1).
module byte_lane_unit
   import mem_pkg::*;
#(
   parameter bit MERGE = 1'b0
) (
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  offs,
   input  logic [1:0]  size,
   input  logic        ld_uns,
   output logic [31:0] dout
);

   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] ld;
   logic [31:0] st;

   always_comb begin
      b  = word[{offs, 3'b000} +: 8];
      h  = word[{offs[1], 4'b0000} +: 16];
      ld = word;
      st = word;
      case (size)
         SZ_BYTE: begin
            ld = {{24{b[7] & ~ld_uns}}, b};
            st[{offs, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            ld = {{16{h[15] & ~ld_uns}}, h};
            st[{offs[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: begin
            ld = word;
            st = wdata;
         end
      endcase
      dout = MERGE ? st : ld;
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: word-indexed memory, aligned loads, sub-word stores via one-stall RMW.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        size,
   input  logic              ld_uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_write,
   output logic              dm_read,
   input  logic [DATA_W-1:0] dm_data
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] merge_q, merge_d;
   logic              misalign_q, misalign_d;
   logic [DATA_W-1:0] ld_word, mg_word;
   logic [1:0]        offs;
   logic              sub_word;
   logic              mis;

   assign dm_addr    = {2'b00, addr[ADDR_W-1:2]};
   assign misalign_o = misalign_q;
   assign sub_word   = (size == SZ_BYTE) || (size == SZ_HALF);

   // With CHECK_ALIGN=0 the low address bits are simply truncated to the access size.
   always_comb begin
      offs = 2'b00;
      if (size == SZ_BYTE) begin
         offs = addr[1:0];
      end else if (size == SZ_HALF) begin
         offs = {addr[1], 1'b0};
      end
      mis = CHECK_ALIGN && (((size == SZ_HALF) && addr[0]) ||
                            (!sub_word && (addr[1:0] != 2'b00)));
   end

   byte_lane_unit #(.MERGE(1'b0)) u_load (
      .word   (dm_data),
      .wdata  (wdata),
      .offs   (offs),
      .size   (size),
      .ld_uns (ld_uns),
      .dout   (ld_word)
   );

   byte_lane_unit #(.MERGE(1'b1)) u_merge (
      .word   (dm_data),
      .wdata  (wdata),
      .offs   (offs),
      .size   (size),
      .ld_uns (ld_uns),
      .dout   (mg_word)
   );

   always_comb begin
      state_d    = state_q;
      merge_d    = merge_q;
      misalign_d = 1'b0;
      dm_read    = 1'b0;
      dm_write   = 1'b0;
      dm_wdata   = wdata;
      stall_o    = 1'b0;
      rdata_o    = '0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (mem_read || mem_write) begin
                  if (mis) begin
                     misalign_d = 1'b1;
                  end else if (mem_write) begin
                     // Write wins over a simultaneous read; rdata_o stays 0.
                     if (sub_word) begin
                        dm_read = 1'b1;
                        stall_o = 1'b1;
                        merge_d = mg_word;
                        state_d = RMW_WR;
                     end else begin
                        dm_write = 1'b1;
                     end
                  end else begin
                     dm_read = 1'b1;
                     rdata_o = ld_word;
                  end
               end
            end
            RMW_WR: begin
               dm_write = 1'b1;
               dm_wdata = merge_q;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         merge_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         merge_q    <= merge_d;
         misalign_q <= misalign_d;
      end
   end

endmodule
